video_scanout: RTL and testbench
================================

// Module: video_scanout
// PURPOSE
//  Pixel scanout stage directly upstream of the vout_r/g/b/hsync/vsync/active pins and the HDMI Tx.
//  Buffers framebuffer pixel words (valid/ready stream from the DDR3 read path) in a small FIFO.
//  Generates raster timing and emits one registered pixel per active clock.
//  Detects underflow and frame misalignment, and resynchronises on the next start-of-frame word.
// PARAMETERS
//  H_ACTIVE 800 | H_FP 40 | H_SYNC 128 | H_BP 88 : horizontal timing, in clocks
//  V_ACTIVE 600 | V_FP 1  | V_SYNC 4   | V_BP 23 : vertical timing, in lines
//  HSYNC_POL 1 | VSYNC_POL 1 : asserted level of hsync/vsync
//  FIFO_DEPTH 16 : pixel FIFO entries (power of 2, >=4)
// PORTS
//  hclk          in   1   sole clock
//  reset         in   1   synchronous, active-high
//  enable        in   1   1 = scan out; 0 = idle/flush
//  pix_data      in   16  {r[4:0],g[4:0],b[5:0]}
//  pix_sof       in   1   word is first pixel of a frame
//  pix_valid     in   1   stream valid
//  pix_ready     out  1   stream ready, = !fifo_full in RUN/SYNC_WAIT; 0 in IDLE
//  underflow_clr in   1   clears underflow
//  vout_r        out  5  | vout_g out 5 | vout_b out 6 : pixel colour
//  vout_hsync    out  1  | vout_vsync out 1 | vout_active out 1
//  frame_start   out  1   1-clk pulse aligned with first active pixel on vout
//  underflow     out  1   sticky error flag
// BEHAVIOUR
//  - Reset: all outputs 0 except hsync=~HSYNC_POL, vsync=~VSYNC_POL. Counters 0, FIFO empty, state IDLE.
//  - Counters: h_cnt 0..H_TOTAL-1; v_cnt increments on h wrap; v_cnt wraps at V_TOTAL.
//  - Timing regions: active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
//  - hsync asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
//  - vsync asserted for whole lines V_ACTIVE+V_FP <= v_cnt < +V_SYNC.
//  - All vout_* registered: outputs reflect counter state of previous clk (latency 1).
//  - Colour is 0 whenever vout_active=0.
//  - Push: pix_valid&&pix_ready. Pop happens at an active counter position; popped data reaches vout next clk.
//  - A push and a pop to an empty FIFO in the same clk: the push is not visible, so this is an underflow.
//  - FSM:
//    - IDLE: enable=0. Counters held 0, FIFO flushed, outputs at reset values. enable=1 -> SYNC_WAIT.
//    - SYNC_WAIT: timing runs, active pixels output black.
//      - Head words with sof=0 are popped and discarded.
//      - At h_cnt=0&&v_cnt=0 with head sof=1 -> RUN; this pixel is popped and shown.
//    - RUN: each active position pops one word.
//      - FIFO empty: output black, set underflow, bad_frame=1.
//      - Head sof=1 at a non-first position: not popped, output black, set underflow, bad_frame=1.
//      - Head sof=0 at (0,0): set underflow -> SYNC_WAIT.
//      - At end of frame (last clk of V_TOTAL) with bad_frame: clear it -> SYNC_WAIT.
//  - enable 1->0 in any state: IDLE next clk. Reset mid-frame is identical to power-on reset.
//  - underflow: set has priority over underflow_clr in the same clk.
//  - frame_start pulses on the first active pixel of every frame while in RUN.
// CONFIGURATION
//  VSCAN_TESTBAR_EN defined:
//    - Adds input pattern_en (1 bit).
//    - pattern_en=1: 8 vertical bars, idx=(h_cnt*8)/H_ACTIVE. r=idx[2]?5'h1F:0, g=idx[1]?5'h1F:0, b=idx[0]?6'h3F:0.
//    - pattern_en=1: FIFO flushed, pix_ready=1 (input discarded), FSM forced to SYNC_WAIT, underflow not set.
//    - Timing, frame_start and sync outputs are unchanged.
//  Undefined: no pattern_en port; behaviour identical to pattern_en=0.
// TESTING (small timing: H 8/2/2/2 -> H_TOTAL=14, V 4/1/1/1 -> V_TOTAL=7)
//  - Reset, enable=0 for 20 clk -> hsync=vsync=~POL, active=0, pix_ready=0, colours 0.
//  - enable=1, stream 32 words 0x0001.. with sof on first, always valid:
//    - frame 2 first active line shows 0x0001..0x0008.
//    - hsync high h_cnt 10-11; vsync high on line 5.
//    - frame_start single pulse per frame.
//  - Stall pix_valid after 12 words in RUN -> pixels 13+ black, underflow=1.
//    Next frame stays black until a sof word arrives; resumes at following (0,0).
//  - sof word injected as pixel 5 -> black from pixel 5, underflow=1, SYNC_WAIT at frame end.
//    underflow_clr with no new error -> 0.
//  - enable 1->0 mid-line with FIFO holding 9 words -> next clk IDLE, FIFO empty, outputs at reset values.
//  - VSCAN_TESTBAR_EN, pattern_en=1 -> line = colours idx 0..7 (000000,...,FFFF as {r,g,b} max).
//    pix_ready=1, underflow stays 0.

Source files
------------

// File: rtl/video_scanout.sv
// Pixel scanout: FIFO-buffered framebuffer stream, raster timing and registered video pins,
// with underflow/misalignment detection. Define VSCAN_TESTBAR_EN to add the pattern_en colour-bar source.
module video_scanout #(
    parameter int   H_ACTIVE   = 800,
    parameter int   H_FP       = 40,
    parameter int   H_SYNC     = 128,
    parameter int   H_BP       = 88,
    parameter int   V_ACTIVE   = 600,
    parameter int   V_FP       = 1,
    parameter int   V_SYNC     = 4,
    parameter int   V_BP       = 23,
    parameter logic HSYNC_POL  = 1'b1,
    parameter logic VSYNC_POL  = 1'b1,
    parameter int   FIFO_DEPTH = 16
) (
    input  logic        hclk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] pix_data,
    input  logic        pix_sof,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        underflow_clr,
`ifdef VSCAN_TESTBAR_EN
    input  logic        pattern_en,
`endif
    output logic [4:0]  vout_r,
    output logic [4:0]  vout_g,
    output logic [5:0]  vout_b,
    output logic        vout_hsync,
    output logic        vout_vsync,
    output logic        vout_active,
    output logic        frame_start,
    output logic        underflow
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {IDLE, SYNC_WAIT, RUN} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [16:0]   mem_q [FIFO_DEPTH];
    logic          bad_frame_q, bad_frame_d;
    logic [15:0]   rgb_q, rgb_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
    logic          frame_start_q, frame_start_d, underflow_q, underflow_d;

    logic          fifo_empty, fifo_full, head_sof, push, pop, flush, show, uf_set;
    logic          pos_active, pos_first, pos_last, pat;
    logic [15:0]   head_data;

`ifdef VSCAN_TESTBAR_EN
    logic [2:0] bar_idx;
    assign pat     = pattern_en;
    assign bar_idx = 3'((32'(h_cnt_q) * 32'd8) / 32'(H_ACTIVE));
`else
    assign pat = 1'b0;
`endif

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_sof   = mem_q[rd_ptr_q[AW-1:0]][16];
    assign head_data  = mem_q[rd_ptr_q[AW-1:0]][15:0];
    // In pattern mode the stream is accepted and thrown away so upstream never backs up.
    assign pix_ready  = (state_q != IDLE) && (pat || !fifo_full);

    assign pos_active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign pos_first  = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign pos_last   = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

    always_comb begin
        state_d       = state_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        bad_frame_d   = bad_frame_q;
        pop           = 1'b0;
        show          = 1'b0;
        uf_set        = 1'b0;
        flush         = 1'b0;
        frame_start_d = 1'b0;

        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end else begin
            h_cnt_d = h_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                flush   = 1'b1;
                state_d = SYNC_WAIT;
            end
            SYNC_WAIT: begin
                if (!fifo_empty) begin
                    if (!head_sof) begin
                        pop = 1'b1;
                    end else if (pos_first) begin
                        pop           = 1'b1;
                        show          = 1'b1;
                        frame_start_d = 1'b1;
                        state_d       = RUN;
                    end
                end
            end
            RUN: begin
                // Pop only sees words already in the FIFO; a same-clock push cannot rescue an empty one.
                if (pos_active) begin
                    if (fifo_empty || (head_sof && !pos_first)) begin
                        uf_set      = 1'b1;
                        bad_frame_d = 1'b1;
                    end else if (!head_sof && pos_first) begin
                        uf_set  = 1'b1;
                        state_d = SYNC_WAIT;
                    end else begin
                        pop           = 1'b1;
                        show          = 1'b1;
                        frame_start_d = pos_first;
                    end
                end
                if (pos_last && bad_frame_q) state_d = SYNC_WAIT;
            end
            default: state_d = IDLE;
        endcase

        if (pat && state_q != IDLE) begin
            state_d       = SYNC_WAIT;
            flush         = 1'b1;
            pop           = 1'b0;
            show          = 1'b0;
            uf_set        = 1'b0;
            frame_start_d = pos_first;
        end
        if (!enable) begin
            state_d       = IDLE;
            h_cnt_d       = '0;
            v_cnt_d       = '0;
            flush         = 1'b1;
            pop           = 1'b0;
            show          = 1'b0;
            uf_set        = 1'b0;
            frame_start_d = 1'b0;
        end
        if (state_d != RUN) bad_frame_d = 1'b0;

        push     = pix_valid && pix_ready && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end

        hsync_d  = (h_cnt_q >= HS_BEG && h_cnt_q < HS_END) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d  = (v_cnt_q >= VS_BEG && v_cnt_q < VS_END) ? VSYNC_POL : ~VSYNC_POL;
        active_d = pos_active;
        rgb_d    = show ? head_data : 16'h0000;
`ifdef VSCAN_TESTBAR_EN
        if (pat && pos_active)
            rgb_d = {bar_idx[2] ? 5'h1F : 5'h00, bar_idx[1] ? 5'h1F : 5'h00, bar_idx[0] ? 6'h3F : 6'h00};
`endif
        underflow_d = uf_set ? 1'b1 : (underflow_clr ? 1'b0 : underflow_q);
        if (state_q == IDLE || !enable) begin
            hsync_d       = ~HSYNC_POL;
            vsync_d       = ~VSYNC_POL;
            active_d      = 1'b0;
            rgb_d         = 16'h0000;
            frame_start_d = 1'b0;
            underflow_d   = 1'b0;
        end
    end

    always_ff @(posedge hclk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {pix_sof, pix_data};
    end

    always_ff @(posedge hclk) begin
        if (reset) begin
            state_q       <= IDLE;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            bad_frame_q   <= 1'b0;
            rgb_q         <= '0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            bad_frame_q   <= bad_frame_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign vout_r      = rgb_q[15:11];
    assign vout_g      = rgb_q[10:6];
    assign vout_b      = rgb_q[5:0];
    assign vout_hsync  = hsync_q;
    assign vout_vsync  = vsync_q;
    assign vout_active = active_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;
endmodule

// File: tb/tb_video_scanout.sv
// Bench for video_scanout on a 14x7 raster: directed frames with a scoreboard of expected
// {frame_start, rgb} per active output. With VSCAN_TESTBAR_EN it also covers the colour bars.
module tb_video_scanout;
    localparam int HT = 14;
    localparam int VT = 7;
    localparam int FT = HT * VT;

    logic        hclk = 1'b0;
    logic        reset, enable, pix_sof, pix_valid, pix_ready, underflow_clr;
    logic [15:0] pix_data;
    logic [4:0]  vout_r, vout_g;
    logic [5:0]  vout_b;
    logic        vout_hsync, vout_vsync, vout_active, frame_start, underflow;
`ifdef VSCAN_TESTBAR_EN
    logic        pattern_en;
`endif

    video_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .FIFO_DEPTH(16)
    ) dut (
        .hclk(hclk), .reset(reset), .enable(enable),
        .pix_data(pix_data), .pix_sof(pix_sof), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .underflow_clr(underflow_clr),
`ifdef VSCAN_TESTBAR_EN
        .pattern_en(pattern_en),
`endif
        .vout_r(vout_r), .vout_g(vout_g), .vout_b(vout_b),
        .vout_hsync(vout_hsync), .vout_vsync(vout_vsync), .vout_active(vout_active),
        .frame_start(frame_start), .underflow(underflow)
    );

    always #5 hclk = ~hclk;

    int          checks = 0;
    int          failures = 0;
    logic [16:0] feed_q[$];  // {sof, data} offered on the stream
    logic [16:0] exp_q[$];   // {frame_start, rgb} per active output
    int          pos;        // raster position the DUT counters hold this cycle, -1 = idle
    bit          en_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic exp_frame(input int base, input int n, input bit fs);
        for (int i = 0; i < 32; i++)
            exp_q.push_back({fs && (i == 0), (i < n) ? 16'(base + i) : 16'h0000});
    endtask

    task automatic check_out(input int p);
        logic [16:0] e;
        int          h, v;
        logic        ea, eh, ev;
        if (p < 0) begin
            chk("reset_outs", 32'({vout_hsync, vout_vsync, vout_active, frame_start, vout_r, vout_g, vout_b}), 32'h0);
            return;
        end
        h  = p % HT;
        v  = (p / HT) % VT;
        ea = (h < 8) && (v < 4);
        eh = (h >= 10) && (h < 12);
        ev = (v == 5);
        chk("timing", 32'({vout_hsync, vout_vsync, vout_active}), 32'({eh, ev, ea}));
        if (ea) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL sb_underrun observed=empty expected=entry pos=%0d", p);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pixel", 32'({vout_r, vout_g, vout_b}), 32'(e[15:0]));
                chk("frame_start", 32'(frame_start), 32'(e[16]));
            end
        end else begin
            chk("blank", 32'({frame_start, vout_r, vout_g, vout_b}), 32'h0);
        end
    endtask

    task automatic step();
        logic rdy;
        if (!enable || !en_prev) pos = -1;
        pix_valid = (feed_q.size() != 0);
        {pix_sof, pix_data} = pix_valid ? feed_q[0] : 17'h0;
        #1;
        rdy = pix_ready;
        @(posedge hclk);
        #1;
        if (pix_valid && rdy) void'(feed_q.pop_front());
        check_out(pos);
        pos++;
        en_prev = enable;
    endtask

    task automatic run_to(input int p);
        while (pos < p) step();
    endtask

`ifdef VSCAN_TESTBAR_EN
    task automatic exp_bars();
        logic [2:0] hb;
        for (int i = 0; i < 32; i++) begin
            hb = 3'(i % 8);
            exp_q.push_back({i == 0, hb[2] ? 5'h1F : 5'h00, hb[1] ? 5'h1F : 5'h00, hb[0] ? 6'h3F : 6'h00});
        end
    endtask
`endif

    initial begin
        reset = 1'b1; enable = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
        underflow_clr = 1'b0; en_prev = 1'b0; pos = -1;
`ifdef VSCAN_TESTBAR_EN
        pattern_en = 1'b0;
`endif
        repeat (3) @(posedge hclk);
        #1;
        chk("rst_outs", 32'({vout_hsync, vout_vsync, vout_active, frame_start, underflow, vout_r, vout_g, vout_b}), 32'h0);
        chk("rst_ready", 32'(pix_ready), 32'h0);
        reset = 1'b0;

        // Disabled: pins parked at reset values.
        repeat (20) step();
        chk("idle_ready", 32'(pix_ready), 32'h0);
        chk("idle_uf", 32'(underflow), 32'h0);

        // Stream 1..32 (frame) then 33..44 which stalls after 12 words of the next frame.
        for (int i = 1; i <= 44; i++) feed_q.push_back({(i == 1) || (i == 33), 16'(i)});
        exp_frame(0, 0, 1'b0);
        exp_frame(1, 32, 1'b1);
        exp_frame(33, 12, 1'b1);
        exp_frame(0, 0, 1'b0);
        enable = 1'b1;
        run_to(50);
        chk("ready_full", 32'(pix_ready), 32'h0);
        chk("uf_sync", 32'(underflow), 32'h0);
        run_to(2 * FT + 18);
        chk("uf_before_stall", 32'(underflow), 32'h0);
        step();
        chk("uf_stall", 32'(underflow), 32'h1);

        // Black frame in SYNC_WAIT, then resume; then a stray sof at pixel 5 and resync on it.
        run_to(3 * FT + 30);
        for (int i = 101; i <= 132; i++) feed_q.push_back({i == 101, 16'(i)});
        for (int i = 201; i <= 236; i++) feed_q.push_back({(i == 201) || (i == 205), 16'(i)});
        exp_frame(101, 32, 1'b1);
        exp_frame(201, 4, 1'b1);
        exp_frame(205, 32, 1'b1);
        exp_frame(0, 0, 1'b0);
        run_to(5 * FT);
        chk("uf_sticky", 32'(underflow), 32'h1);
        run_to(6 * FT + 50);
        chk("uf_before_clr", 32'(underflow), 32'h1);
        underflow_clr = 1'b1;
        step();
        underflow_clr = 1'b0;
        chk("uf_clr", 32'(underflow), 32'h0);
        run_to(7 * FT);
        chk("uf_stays_clr", 32'(underflow), 32'h0);
        underflow_clr = 1'b1;
        step();
        underflow_clr = 1'b0;
        chk("uf_set_prio", 32'(underflow), 32'h1);

        // Park 9 words (sof head stuck mid-frame), then disable mid-line.
        run_to(7 * FT + 10);
        for (int i = 301; i <= 309; i++) feed_q.push_back({i == 301, 16'(i)});
        run_to(7 * FT + 31);
        chk("nine_accepted", 32'(feed_q.size()), 32'h0);
        enable = 1'b0;
        exp_q.delete();
        step();
        chk("dis_ready", 32'(pix_ready), 32'h0);
        chk("dis_uf", 32'(underflow), 32'h0);
        repeat (4) step();

        // Re-enable with nothing streamed: a flushed FIFO never syncs.
        exp_frame(0, 0, 1'b0);
        exp_frame(0, 0, 1'b0);
        enable = 1'b1;
        run_to(2 * FT);
        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        chk("reen_uf", 32'(underflow), 32'h0);

`ifdef VSCAN_TESTBAR_EN
        for (int i = 0; i < 40; i++) feed_q.push_back({i == 0, 16'(500 + i)});
        exp_bars();
        exp_bars();
        pattern_en = 1'b1;
        run_to(3 * FT);
        chk("pat_ready", 32'(pix_ready), 32'h1);
        chk("pat_discard", 32'(feed_q.size()), 32'h0);
        run_to(4 * FT);
        chk("pat_uf", 32'(underflow), 32'h0);
        chk("pat_drained", 32'(exp_q.size()), 32'h0);
        pattern_en = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
